div_ctrl: RTL and testbench

Multi-cycle divide sequencer serving the ALU's divide request interface (DIV, DIVU, REM, REMU).
- The ALU holds `start_i` high with stable operands until `ready_o` pulses, then drops `start_i` in the same cycle.
- The block latches operands, runs a radix-2 restoring division (one quotient bit per cycle) and applies RISC-V sign, divide-by-zero and overflow rules.
- It returns a single 32-bit result: quotient or remainder, selected by `op_i`.

---
 rtl/div_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divide sequencer for DIV/DIVU/REM/REMU with RISC-V corner-case rules.
// Optional macro DIV_RESULT_REUSE_EN keeps the last computed quotient/remainder so a matching request finishes in one cycle.
module div_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam logic [CNT_WIDTH-1:0]  LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES  = '1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] negate_if(input logic [DATA_WIDTH-1:0] val,
                                                        input logic                  neg);
        logic signed [DATA_WIDTH-1:0] sval;
        sval = $signed(val);
        return neg ? $unsigned(-sval) : val;
    endfunction

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quot;
    logic [DATA_WIDTH-1:0] dvs;
    logic [DATA_WIDTH-1:0] result;
    logic                  rem_sel;
    logic                  neg_q;
    logic                  neg_r;

    logic                  accept;
    logic                  is_signed;
    logic                  dd_neg;
    logic                  ds_neg;
    logic                  div_zero;
    logic                  overflow;
    logic                  fast;
    logic                  hit;
    logic [DATA_WIDTH-1:0] dd_abs;
    logic [DATA_WIDTH-1:0] ds_abs;
    logic [DATA_WIDTH-1:0] fast_result;
    logic [DATA_WIDTH-1:0] hit_result;

    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;
    logic                  ge;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quot_step;
    logic [DATA_WIDTH-1:0] quot_fin;
    logic [DATA_WIDTH-1:0] rem_fin;
    logic [DATA_WIDTH-1:0] calc_result;

    assign accept = (state == IDLE) && start_i && !flush_i;

    // Request decode: magnitudes, sign flags and the single-cycle special cases
    always_comb begin
        is_signed = ~op_i[0];
        dd_neg    = is_signed & dividend_i[DATA_WIDTH-1];
        ds_neg    = is_signed & divisor_i[DATA_WIDTH-1];
        dd_abs    = negate_if(dividend_i, dd_neg);
        ds_abs    = negate_if(divisor_i, ds_neg);
        div_zero  = (divisor_i == '0);
        overflow  = is_signed && (dividend_i == MIN_NEG) && (divisor_i == ALL_ONES);
        fast      = div_zero | overflow;
        if (div_zero) begin
            fast_result = op_i[1] ? dividend_i : ALL_ONES;
        end else begin
            fast_result = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step; the extra top bit of trial covers divisors above 2^(W-1)
    always_comb begin
        trial       = {rem, quot[DATA_WIDTH-1]};
        diff        = trial - {1'b0, dvs};
        ge          = ~diff[DATA_WIDTH];
        rem_step    = ge ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        quot_step   = {quot[DATA_WIDTH-2:0], ge};
        quot_fin    = negate_if(quot_step, neg_q);
        rem_fin     = negate_if(rem_step, neg_r);
        calc_result = rem_sel ? rem_fin : quot_fin;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (fast || hit) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            dvs     <= '0;
            result  <= '0;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            rem_sel <= op_i[1];
            neg_q   <= dd_neg ^ ds_neg;
            neg_r   <= dd_neg;
            cnt     <= '0;
            rem     <= '0;
            quot    <= dd_abs;
            dvs     <= ds_abs;
            if (fast) begin
                result <= fast_result;
            end else if (hit) begin
                result <= hit_result;
            end
        end else if (state == CALC && !flush_i) begin
            cnt  <= cnt + CNT_WIDTH'(1);
            rem  <= rem_step;
            quot <= quot_step;
            if (cnt == LAST_ITER) begin
                result <= calc_result;
            end
        end
    end

`ifdef DIV_RESULT_REUSE_EN
    logic [DATA_WIDTH-1:0] req_dd;
    logic [DATA_WIDTH-1:0] req_ds;
    logic                  req_sgn;
    logic [DATA_WIDTH-1:0] last_dd;
    logic [DATA_WIDTH-1:0] last_ds;
    logic                  last_sgn;
    logic [DATA_WIDTH-1:0] last_quot;
    logic [DATA_WIDTH-1:0] last_rem;
    logic                  last_vld;

    // Raw operands are kept for the whole calculation so the entry matches future requests exactly
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_dd    <= '0;
            req_ds    <= '0;
            req_sgn   <= 1'b0;
            last_dd   <= '0;
            last_ds   <= '0;
            last_sgn  <= 1'b0;
            last_quot <= '0;
            last_rem  <= '0;
            last_vld  <= 1'b0;
        end else begin
            if (accept) begin
                req_dd  <= dividend_i;
                req_ds  <= divisor_i;
                req_sgn <= is_signed;
            end
            if (state == CALC) begin
                if (flush_i) begin
                    last_vld <= 1'b0;
                end else if (cnt == LAST_ITER) begin
                    last_vld  <= 1'b1;
                    last_dd   <= req_dd;
                    last_ds   <= req_ds;
                    last_sgn  <= req_sgn;
                    last_quot <= quot_fin;
                    last_rem  <= rem_fin;
                end
            end
        end
    end

    assign hit = last_vld && (last_dd == dividend_i) && (last_ds == divisor_i)
                 && (last_sgn == is_signed);
    assign hit_result = op_i[1] ? last_rem : last_quot;
`else
    assign hit        = 1'b0;
    assign hit_result = '0;
`endif

    // A flush arriving in DONE suppresses the pulse that would otherwise appear that cycle
    assign busy_o   = (state == CALC) || (state == DONE);
    assign ready_o  = (state == DONE) && !flush_i;
    assign result_o = ready_o ? result : '0;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomised self-checking bench for div_ctrl, compared against a plain-arithmetic RISC-V divide model.
module tb_div_ctrl;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
    localparam logic [W-1:0] NEG_ONE = 32'hFFFF_FFFF;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         busy;
    logic         ready;
    logic [W-1:0] result;

    int n_cmp;
    int n_bad;

    // Model of the reuse entry: last normally completed operands
    logic         m_vld;
    logic [W-1:0] m_dd;
    logic [W-1:0] m_ds;
    logic         m_sgn;

    div_ctrl #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .busy_o     (busy),
        .ready_o    (ready),
        .result_o   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_result(input logic [1:0] o, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = a;
        sb = b;
        if (b == '0) return o[1] ? a : NEG_ONE;
        if (!o[0] && a == MIN_NEG && b == NEG_ONE) return o[1] ? '0 : MIN_NEG;
        if (!o[0]) return o[1] ? sa % sb : sa / sb;
        return o[1] ? a % b : a / b;
    endfunction

    function automatic bit model_fast(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) || (!o[0] && a == MIN_NEG && b == NEG_ONE);
    endfunction

    function automatic bit model_hit(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_RESULT_REUSE_EN
        return m_vld && m_dd == a && m_ds == b && m_sgn == !o[0];
`else
        return 1'b0;
`endif
    endfunction

    // Starts in an IDLE cycle (cycle 0) and ends in the IDLE cycle after the ready pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res);
        int       lat;
        int       exp_lat;
        bit       fast;
        bit       hit;
        bit       leak;
        logic [W-1:0] got;
        fast    = model_fast(o, a, b);
        hit     = !fast && model_hit(o, a, b);
        exp_lat = (fast || hit) ? 1 : W + 1;
        lat     = -1;
        leak    = 1'b0;
        got     = '0;
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int k = 1; k <= W + 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check({tag, ".busy_c1"}, 64'(busy), 64'(1));
            if (ready) begin
                lat = k;
                got = result;
                break;
            end
            if (result != '0) leak = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            op       = 2'($urandom);
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, 64'(got), 64'(exp_res));
        check({tag, ".result_idle_zero"}, 64'(leak), 64'(0));
        @(posedge clk);
        #1;
        check({tag, ".busy_after"}, 64'(busy), 64'(0));
        check({tag, ".ready_after"}, 64'(ready), 64'(0));
        if (!fast) begin
            m_vld = 1'b1;
            m_dd  = a;
            m_ds  = b;
            m_sgn = !o[0];
        end
    endtask

    initial begin
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        bit           seen;
        n_cmp    = 0;
        n_bad    = 0;
        m_vld    = 1'b0;
        m_dd     = '0;
        m_ds     = '0;
        m_sgn    = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.ready", 64'(ready), 64'(0));
        check("reset.result", 64'(result), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("t1_div", 2'b00, 32'd20, 32'd3, 32'd6);
        run_op("t2_rem", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run_op("t2_div", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run_op("t3_divu0", 2'b01, 32'd123, 32'd0, 32'hFFFF_FFFF);
        run_op("t3_remu0", 2'b11, 32'd123, 32'd0, 32'd123);
        run_op("t4_div_ovf", 2'b00, MIN_NEG, NEG_ONE, MIN_NEG);
        run_op("t4_rem_ovf", 2'b10, MIN_NEG, NEG_ONE, 32'd0);

        // Flush in the middle of a calculation
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        seen     = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        if (ready) seen = 1'b1;
        check("t5_flush.busy", 64'(busy), 64'(0));
        check("t5_flush.no_ready", 64'(seen), 64'(0));
        flush = 1'b0;
        m_vld = 1'b0;
        run_op("t5_divu", 2'b01, 32'd1000, 32'd7, 32'd142);

        run_op("t6_div", 2'b00, 32'd100, 32'd7, 32'd14);
        run_op("t6_rem", 2'b10, 32'd100, 32'd7, 32'd2);

        // Flush together with start in IDLE drops the request
        op       = 2'b00;
        dividend = 32'd55;
        divisor  = 32'd5;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start.busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check("flush_start.ready", 64'(ready), 64'(0));

        // Reset in the middle of a calculation
        op       = 2'b01;
        dividend = 32'd999;
        divisor  = 32'd4;
        start    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midreset.busy", 64'(busy), 64'(0));
        check("midreset.ready", 64'(ready), 64'(0));
        check("midreset.result", 64'(result), 64'(0));
        rst   = 1'b0;
        m_vld = 1'b0;
        @(posedge clk);
        #1;

        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            o   = 2'($urandom);
            case (sel)
                0: begin a = $urandom; b = '0; end
                1: begin a = MIN_NEG; b = NEG_ONE; end
                2: begin end
                3: begin
                    a = 32'($urandom_range(0, 1000));
                    b = 32'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: begin
                    a = $urandom;
                    b = $urandom >> $urandom_range(0, 31);
                end
            endcase
            run_op($sformatf("rand%0d", i), o, a, b, model_result(o, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
